// File: rtl/wb_merge.sv
// Writeback merge: packs two ALU results and queued load returns onto the
// register file's two write ports. Optional `WB_PERF_EN adds stall/drop counters.
module wb_merge #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a0_valid,
  input  logic [4:0]  a0_rd,
  input  logic [31:0] a0_data,
  input  logic        a1_valid,
  input  logic [4:0]  a1_rd,
  input  logic [31:0] a1_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        we1,
  output logic [4:0]  w_addr1,
  output logic [31:0] w_data1,
  output logic        we2,
  output logic [4:0]  w_addr2,
  output logic [31:0] w_data2,
  output logic        ld_drop
`ifdef WB_PERF_EN
  ,
  output logic [31:0] perf_ld_stall,
  output logic [31:0] perf_ld_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          s0_ok, s1_ok;
  logic          p1_en, p2_alu_en;
  logic [4:0]    p1_rd, p2_rd;
  logic [31:0]   p1_data, p2_data;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          head_hit, ld_wr, drop_now;

  // Slot 0 loses to a same-rd slot 1 because slot 1 is younger.
  assign s1_ok = a1_valid && (a1_rd != 5'd0);
  assign s0_ok = a0_valid && (a0_rd != 5'd0) && !(s1_ok && (a1_rd == a0_rd));

  always_comb begin
    p1_en     = 1'b0;
    p1_rd     = a0_rd;
    p1_data   = a0_data;
    p2_alu_en = 1'b0;
    p2_rd     = a1_rd;
    p2_data   = a1_data;
    if (s0_ok) begin
      p1_en     = 1'b1;
      p2_alu_en = s1_ok;
    end else if (s1_ok) begin
      p1_en   = 1'b1;
      p1_rd   = a1_rd;
      p1_data = a1_data;
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign ld_ready   = !rst && !fifo_full;
  assign push       = ld_valid && ld_ready;

  assign head_rd   = mem[rd_ptr][36:32];
  assign head_data = mem[rd_ptr][31:0];

  // The head only drains through port 2, so it can only collide with port 1.
  assign pop      = !fifo_empty && !p2_alu_en;
  assign head_hit = p1_en && (head_rd == p1_rd);
  assign ld_wr    = pop && (head_rd != 5'd0) && !head_hit;
  assign drop_now = pop && (head_rd != 5'd0) && head_hit;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ld_rd, ld_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we1     <= 1'b0;
      w_addr1 <= '0;
      w_data1 <= '0;
      we2     <= 1'b0;
      w_addr2 <= '0;
      w_data2 <= '0;
      ld_drop <= 1'b0;
    end else begin
      we1     <= p1_en;
      we2     <= p2_alu_en || ld_wr;
      ld_drop <= drop_now;
      if (p1_en) begin
        w_addr1 <= p1_rd;
        w_data1 <= p1_data;
      end
      if (p2_alu_en) begin
        w_addr2 <= p2_rd;
        w_data2 <= p2_data;
      end else if (ld_wr) begin
        w_addr2 <= head_rd;
        w_data2 <= head_data;
      end
    end
  end

`ifdef WB_PERF_EN
  logic stall_now;
  assign stall_now = !fifo_empty && p2_alu_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_stall <= '0;
      perf_ld_drop  <= '0;
    end else begin
      if (stall_now) perf_ld_stall <= perf_ld_stall + 32'd1;
      if (drop_now)  perf_ld_drop  <= perf_ld_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: queue-based reference model checked every cycle plus
// hand-computed literal expectations for the directed scenarios.
module tb_wb_merge;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a0_valid, a1_valid, ld_valid;
  logic [4:0]  a0_rd, a1_rd, ld_rd;
  logic [31:0] a0_data, a1_data, ld_data;
  logic        ld_ready;
  logic        we1, we2, ld_drop;
  logic [4:0]  w_addr1, w_addr2;
  logic [31:0] w_data1, w_data2;
`ifdef WB_PERF_EN
  logic [31:0] perf_ld_stall, perf_ld_drop;
`endif

  int vectors = 0;
  int miscompares = 0;

  wb_merge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a0_valid(a0_valid), .a0_rd(a0_rd), .a0_data(a0_data),
    .a1_valid(a1_valid), .a1_rd(a1_rd), .a1_data(a1_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
    .we2(we2), .w_addr2(w_addr2), .w_data2(w_data2),
    .ld_drop(ld_drop)
`ifdef WB_PERF_EN
    , .perf_ld_stall(perf_ld_stall), .perf_ld_drop(perf_ld_drop)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what the register file should see, from the merge rules.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        alu_w[$];
  ent_t        hd;
  bit          rdy, hit;
  logic        e_we1 = 0, e_we2 = 0, e_drop = 0;
  logic [4:0]  e_a1 = 0, e_a2 = 0;
  logic [31:0] e_d1 = 0, e_d2 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      e_we1 = 0; e_we2 = 0; e_drop = 0;
      e_a1 = 0; e_a2 = 0; e_d1 = 0; e_d2 = 0;
    end else begin
      alu_w.delete();
      if (a0_valid && a0_rd != 0 && !(a1_valid && a1_rd == a0_rd))
        alu_w.push_back('{a0_rd, a0_data});
      if (a1_valid && a1_rd != 0)
        alu_w.push_back('{a1_rd, a1_data});
      rdy = (q.size() < DEPTH);
      e_we1 = 0; e_we2 = 0; e_drop = 0;
      if (alu_w.size() >= 1) begin
        e_we1 = 1; e_a1 = alu_w[0].rd; e_d1 = alu_w[0].data;
      end
      if (alu_w.size() == 2) begin
        e_we2 = 1; e_a2 = alu_w[1].rd; e_d2 = alu_w[1].data;
      end else if (q.size() > 0) begin
        hd = q.pop_front();
        hit = 0;
        foreach (alu_w[i]) if (alu_w[i].rd == hd.rd) hit = 1;
        if (hd.rd != 0) begin
          if (hit) e_drop = 1;
          else begin
            e_we2 = 1; e_a2 = hd.rd; e_d2 = hd.data;
          end
        end
      end
      if (ld_valid && rdy) q.push_back('{ld_rd, ld_data});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("we1", {31'd0, we1}, {31'd0, e_we1});
    chk("we2", {31'd0, we2}, {31'd0, e_we2});
    chk("w_addr1", {27'd0, w_addr1}, {27'd0, e_a1});
    chk("w_addr2", {27'd0, w_addr2}, {27'd0, e_a2});
    chk("w_data1", w_data1, e_d1);
    chk("w_data2", w_data2, e_d2);
    chk("ld_drop", {31'd0, ld_drop}, {31'd0, e_drop});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, (!rst && q.size() < DEPTH)});
    if (we1 && we2)
      if (w_addr1 == w_addr2 || w_addr1 == 0 || w_addr2 == 0) begin
        vectors++; miscompares++;
        $display("FAIL port_addr_distinct: got %0d/%0d expected distinct nonzero", w_addr1, w_addr2);
      end
  end

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ldd);
    a0_valid = v0; a0_rd = r0; a0_data = d0;
    a1_valid = v1; a1_rd = r1; a1_data = d1;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we1", {31'd0, we1}, 32'd0);
    chk("rst_we2", {31'd0, we2}, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, ld_ready}, 32'd1);

    // two distinct ALU writes
    drive(1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0);
    tick();
    chk("t1_we1", {31'd0, we1}, 32'd1);
    chk("t1_a1", {27'd0, w_addr1}, 32'd5);
    chk("t1_d1", w_data1, 32'h11);
    chk("t1_we2", {31'd0, we2}, 32'd1);
    chk("t1_a2", {27'd0, w_addr2}, 32'd6);
    chk("t1_d2", w_data2, 32'h22);

    // same rd: slot 1 wins
    drive(1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 0);
    tick();
    chk("t2_we1", {31'd0, we1}, 32'd1);
    chk("t2_a1", {27'd0, w_addr1}, 32'd7);
    chk("t2_d1", w_data1, 32'hBB);
    chk("t2_we2", {31'd0, we2}, 32'd0);
    drive(1, 0, 32'hCC, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_x0_we1", {31'd0, we1}, 32'd0);
    chk("t2_x0_hold_a1", {27'd0, w_addr1}, 32'd7);

    // single load, no ALU traffic: written at N+2 on port 2
    drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h1234);
    tick();
    chk("t3_n1_we2", {31'd0, we2}, 32'd0);
    idle();
    tick();
    chk("t3_we1", {31'd0, we1}, 32'd0);
    chk("t3_we2", {31'd0, we2}, 32'd1);
    chk("t3_a2", {27'd0, w_addr2}, 32'd9);
    chk("t3_d2", w_data2, 32'h1234);

    // fill FIFO behind double ALU traffic
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, 32'hA0 + i, 1, 11, 32'hB0 + i, 1, 5'(12 + i), 32'h100 + i);
      tick();
    end
    chk("t4_full_ready", {31'd0, ld_ready}, 32'd0);
    drive(1, 10, 32'hA9, 1, 11, 32'hB9, 1, 16, 32'h116);
    tick();
    chk("t4_rej_ready", {31'd0, ld_ready}, 32'd0);
    chk("t4_alu_a2", {27'd0, w_addr2}, 32'd11);
    drive(0, 0, 0, 0, 0, 0, 1, 17, 32'h117);
    tick();
    chk("t4_pop0_a2", {27'd0, w_addr2}, 32'd12);
    chk("t4_pop0_we1", {31'd0, we1}, 32'd0);
    chk("t4_ready_back", {31'd0, ld_ready}, 32'd1);
    idle();
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t4_drain_we2", {31'd0, we2}, 32'd1);
      chk("t4_drain_a2", {27'd0, w_addr2}, 32'(12 + i));
      chk("t4_drain_d2", w_data2, 32'h100 + i);
    end
    tick();
    chk("t4_empty_we2", {31'd0, we2}, 32'd0);

    // stale head versus lone ALU write
    drive(0, 0, 0, 0, 0, 0, 1, 3, 32'h5555);
    tick();
    drive(1, 3, 32'h33, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_we1", {31'd0, we1}, 32'd1);
    chk("t5_a1", {27'd0, w_addr1}, 32'd3);
    chk("t5_d1", w_data1, 32'h33);
    chk("t5_we2", {31'd0, we2}, 32'd0);
    chk("t5_drop", {31'd0, ld_drop}, 32'd1);
    idle();
    tick();
    chk("t5_drop_clr", {31'd0, ld_drop}, 32'd0);
    chk("t5_gone_we2", {31'd0, we2}, 32'd0);

    // non-stale head beside a lone ALU write, then an rd=0 load
    drive(0, 0, 0, 0, 0, 0, 1, 4, 32'h4444);
    tick();
    drive(0, 0, 0, 1, 8, 32'h88, 1, 0, 32'hDEAD);
    tick();
    chk("t5b_a1", {27'd0, w_addr1}, 32'd8);
    chk("t5b_a2", {27'd0, w_addr2}, 32'd4);
    chk("t5b_d2", w_data2, 32'h4444);
    idle();
    tick();
    chk("t5c_x0_we2", {31'd0, we2}, 32'd0);
    chk("t5c_x0_drop", {31'd0, ld_drop}, 32'd0);

    // reset with loads queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 20, 32'hC0 + i, 1, 21, 32'hD0 + i, 1, 5'(24 + i), 32'h200 + i);
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    chk("t6_we1", {31'd0, we1}, 32'd0);
    chk("t6_we2", {31'd0, we2}, 32'd0);
    chk("t6_a1", {27'd0, w_addr1}, 32'd0);
    chk("t6_d2", w_data2, 32'd0);
    chk("t6_ready", {31'd0, ld_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready_rel", {31'd0, ld_ready}, 32'd1);
`ifdef WB_PERF_EN
    chk("t6_perf_stall", perf_ld_stall, 32'd0);
    chk("t6_perf_drop", perf_ld_drop, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_wr", {31'd0, we1 | we2}, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 30, 32'h3030);
    tick();
    idle();
    tick();
    chk("t6_new_a2", {27'd0, w_addr2}, 32'd30);
    chk("t6_new_d2", w_data2, 32'h3030);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_merge.md
# wb_merge

Writeback merge stage for the dual-issue RISC-V core; sits directly upstream of the two-write-port register file and drives its `we1/w_addr1/w_data1` and `we2/w_addr2/w_data2` inputs. Takes two in-order ALU results per cycle plus out-of-band load returns, buffers load returns in a small FIFO and packs everything onto the two write ports. It guarantees the register file never sees an x0 write or two same-address writes in one cycle, since both corrupt its XOR-encoded storage.

## Interface
- `DEPTH`, 4: load-return FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a0_valid`, `a1_valid`  in  1  ALU slot results valid; slot 0 is older than slot 1.
- `a0_rd`, `a1_rd`  in  5  destination registers.
- `a0_data`, `a1_data`  in  32  result data.
- `ld_valid`  in  1  load return offered.
- `ld_ready`  out  1  FIFO can accept (`!full`, registered count); 0 while `rst` asserted.
- `ld_rd`  in  5,  `ld_data`  in  32  load destination and data.
- `we1`, `we2`  out  1  register-file write enables (registered).
- `w_addr1`, `w_addr2`  out  5,  `w_data1`, `w_data2`  out  32  write address/data (registered).
- `ld_drop`  out  1  registered pulse: FIFO head discarded this cycle as stale.

## Operation
- Filtering: any ALU or load write with rd=0 is discarded, never reaching a port.
- ALU same-rd: if both slots valid, rd equal and nonzero, slot 0 is discarded; slot 1 is written.
- Packing: surviving ALU writes fill port 1 first, then port 2 (slot 0 → port 1, slot 1 → port 2 when both survive; a lone survivor → port 1).
- Load drain: FIFO head pops when port 2 is unused by ALU writes after packing. A head with rd=0 pops without writing.
- Stale load: if the popped head's rd equals any surviving ALU rd that cycle, the head pops, is not written, `ld_drop`=1 (the ALU write is younger).
- With two surviving ALU writes, the FIFO does not pop.
- FIFO: push when `ld_valid && ld_ready`; pointers wrap modulo DEPTH; count 0..DEPTH; push and pop in the same cycle leave count unchanged.
- Outputs always carry distinct nonzero addresses when both enables are high.
- Disabled port: `we`=0; addr/data hold their previous values.

## Timing
- Reset (async): `we1`=`we2`=0, `w_addr*`=0, `w_data*`=0, `ld_drop`=0, FIFO empty, `ld_ready`=0 during reset, 1 on the first cycle after release.
- ALU result presented in cycle N → write enable high in cycle N+1.
- Load accepted in cycle N → earliest write in cycle N+2 (no same-cycle bypass into the FIFO output).
- `ld_ready` derives from count at cycle start; when full, a same-cycle pop does not raise `ld_ready` until the next cycle.
- Reset mid-operation discards FIFO contents and clears outputs immediately.

## Configuration
- `WB_PERF_EN` defined: adds outputs `perf_ld_stall` (32) and `perf_ld_drop` (32), reset to 0, wrapping at 2^32. `perf_ld_stall` increments each cycle the FIFO is non-empty and blocked by two ALU writes. `perf_ld_drop` increments on each `ld_drop` pulse.
- Undefined: neither port nor counter exists; the remaining behaviour is identical.

## Test plan
- a0 (rd=5, 0x11) and a1 (rd=6, 0x22) in cycle N → cycle N+1: we1=1 addr 5 data 0x11, we2=1 addr 6 data 0x22.
- a0 and a1 both rd=7 (0xAA, 0xBB) → only one port enabled, addr 7, data 0xBB. a0 rd=0 → no write.
- Load rd=9 data 0x1234, no ALU traffic → we1=0, we2=1 addr 9 data 0x1234 at N+2.
- DEPTH=4, two ALU writes every cycle, 5 loads offered → 4 accepted, `ld_ready`=0. Then ALU idles → one load written per cycle, `ld_ready` returns 1 a cycle after the first pop.
- FIFO head rd=3 and a lone ALU write rd=3 in the same cycle → ALU write on port 1, we2=0, `ld_drop`=1, head removed.
- Assert `rst` with 3 loads queued → outputs 0 immediately. After release, FIFO empty, no writes until new input arrives. With `WB_PERF_EN`, counters read 0.
